// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the ID/EX stage: ALU op codes and ALU operand select values.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package id_ex_stage_pkg;

    // ALU op codes; code 0 is the idle op so a bubble drives a harmless ALU.
    localparam logic [3:0] ALU_NOP = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;

    // alu1 operand source
    typedef enum logic {
        ALU1_RS = 1'b0,
        ALU1_RT = 1'b1
    } alu1_sel_e;

    // alu2 operand source
    typedef enum logic [1:0] {
        ALU2_RT    = 2'd0,
        ALU2_IMM   = 2'd1,
        ALU2_SHAMT = 2'd2,
        ALU2_RS    = 2'd3
    } alu2_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Forwarding mux for one source register: EX/MEM result, else MEM/WB result, else latched data.
// Latency: purely combinational.
// Backpressure: none; $0 is never forwarded.
// Ports: reg_num/latched (source), exm_* and wb_* (producer triples), fwd (resolved operand).
module fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW     = 5
) (
    input  logic [REG_AW-1:0]     reg_num,
    input  logic [DATA_WIDTH-1:0] latched,
    input  logic                  exm_regwrite,
    input  logic [REG_AW-1:0]     exm_rd,
    input  logic [DATA_WIDTH-1:0] exm_result,
    input  logic                  wb_regwrite,
    input  logic [REG_AW-1:0]     wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_result,
    output logic [DATA_WIDTH-1:0] fwd
);

    always_comb begin
        fwd = latched;
        // EX/MEM is the younger producer, so it is checked first.
        if (exm_regwrite && (exm_rd == reg_num) && (reg_num != '0)) begin
            fwd = exm_result;
        end else if (wb_regwrite && (wb_rd == reg_num) && (reg_num != '0)) begin
            fwd = wb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding feeding the ALU and EX/MEM.
// Latency: one cycle ID -> registered state; operand muxing is combinational in EX.
// Backpressure: stall holds contents (rs/rt data refreshed from forwarding), flush inserts a bubble.
// Ports: id_* (decoded instruction), stall/flush (hazard unit), exm_*/wb_* (forward sources),
//        ex_*/alu1/alu2 (to ALU and EX/MEM).
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW     = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [3:0]            id_aluctr,
    input  logic [DATA_WIDTH-1:0] id_rs_data,
    input  logic [DATA_WIDTH-1:0] id_rt_data,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic [4:0]            id_shamt,
    input  logic [REG_AW-1:0]     id_rs,
    input  logic [REG_AW-1:0]     id_rt,
    input  logic [REG_AW-1:0]     id_rd,
    input  logic                  id_alu1_sel,
    input  logic [1:0]            id_alu2_sel,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  id_memwrite,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  exm_regwrite,
    input  logic [REG_AW-1:0]     exm_rd,
    input  logic [DATA_WIDTH-1:0] exm_result,
    input  logic                  wb_regwrite,
    input  logic [REG_AW-1:0]     wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_result,
    output logic                  ex_valid,
    output logic [3:0]            ex_aluctr,
    output logic [DATA_WIDTH-1:0] alu1,
    output logic [DATA_WIDTH-1:0] alu2,
    output logic [DATA_WIDTH-1:0] ex_store_data,
    output logic [REG_AW-1:0]     ex_rd,
    output logic                  ex_regwrite,
    output logic                  ex_memread,
    output logic                  ex_memwrite
);

    logic                  valid_q;
    logic [3:0]            aluctr_q;
    logic [DATA_WIDTH-1:0] rs_data_q;
    logic [DATA_WIDTH-1:0] rt_data_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic [4:0]            shamt_q;
    logic [REG_AW-1:0]     rs_q;
    logic [REG_AW-1:0]     rt_q;
    logic [REG_AW-1:0]     rd_q;
    alu1_sel_e             alu1_sel_q;
    alu2_sel_e             alu2_sel_q;
    logic                  regwrite_q;
    logic                  memread_q;
    logic                  memwrite_q;

    logic [DATA_WIDTH-1:0] fwd_rs;
    logic [DATA_WIDTH-1:0] fwd_rt;

    // The register file is read in ID before WB writes it back, so a value
    // retiring on the capture edge is taken from the WB bus instead.
    logic wt_rs;
    logic wt_rt;
    assign wt_rs = wb_regwrite && (wb_rd == id_rs) && (id_rs != '0);
    assign wt_rt = wb_regwrite && (wb_rd == id_rt) && (id_rt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            aluctr_q   <= ALU_NOP;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            shamt_q    <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            alu1_sel_q <= ALU1_RS;
            alu2_sel_q <= ALU2_RT;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
        end else if (flush) begin
            // Bubble: zeroing rs/rt numbers also disables forwarding, so ALU inputs read 0.
            valid_q    <= 1'b0;
            aluctr_q   <= ALU_NOP;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            shamt_q    <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            alu1_sel_q <= ALU1_RS;
            alu2_sel_q <= ALU2_RT;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
        end else if (stall) begin
            // Refresh operands so a producer retiring during the stall is not lost.
            rs_data_q <= fwd_rs;
            rt_data_q <= fwd_rt;
        end else begin
            valid_q    <= id_valid;
            aluctr_q   <= id_aluctr;
            rs_data_q  <= wt_rs ? wb_result : id_rs_data;
            rt_data_q  <= wt_rt ? wb_result : id_rt_data;
            imm_q      <= id_imm;
            shamt_q    <= id_shamt;
            rs_q       <= id_rs;
            rt_q       <= id_rt;
            rd_q       <= id_rd;
            alu1_sel_q <= alu1_sel_e'(id_alu1_sel);
            alu2_sel_q <= alu2_sel_e'(id_alu2_sel);
            regwrite_q <= id_regwrite;
            memread_q  <= id_memread;
            memwrite_q <= id_memwrite;
        end
    end

    fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_AW(REG_AW)) u_fwd_rs (
        .reg_num      (rs_q),
        .latched      (rs_data_q),
        .exm_regwrite (exm_regwrite),
        .exm_rd       (exm_rd),
        .exm_result   (exm_result),
        .wb_regwrite  (wb_regwrite),
        .wb_rd        (wb_rd),
        .wb_result    (wb_result),
        .fwd          (fwd_rs)
    );

    fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_AW(REG_AW)) u_fwd_rt (
        .reg_num      (rt_q),
        .latched      (rt_data_q),
        .exm_regwrite (exm_regwrite),
        .exm_rd       (exm_rd),
        .exm_result   (exm_result),
        .wb_regwrite  (wb_regwrite),
        .wb_rd        (wb_rd),
        .wb_result    (wb_result),
        .fwd          (fwd_rt)
    );

    assign alu1 = (alu1_sel_q == ALU1_RT) ? fwd_rt : fwd_rs;

    always_comb begin
        alu2 = fwd_rt;
        case (alu2_sel_q)
            ALU2_RT:    alu2 = fwd_rt;
            ALU2_IMM:   alu2 = imm_q;
            ALU2_SHAMT: alu2 = {{(DATA_WIDTH-5){1'b0}}, shamt_q};
            ALU2_RS:    alu2 = fwd_rs;
            default:    alu2 = fwd_rt;
        endcase
    end

    assign ex_valid      = valid_q;
    assign ex_aluctr     = aluctr_q;
    assign ex_store_data = fwd_rt;
    assign ex_rd         = rd_q;
    assign ex_regwrite   = regwrite_q & valid_q;
    assign ex_memread    = memread_q & valid_q;
    assign ex_memwrite   = memwrite_q & valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: scoreboard of expected EX outputs.
// Latency: expectations pushed when stimulus is driven, popped when outputs are sampled.
// Backpressure: exercises stall, flush, and asynchronous reset.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [3:0]  aluctr;
        logic [31:0] alu1;
        logic [31:0] alu2;
        logic [31:0] store;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
    } out_t;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [3:0]  id_aluctr;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic [4:0]  id_shamt;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        id_alu1_sel;
    logic [1:0]  id_alu2_sel;
    logic        id_regwrite;
    logic        id_memread;
    logic        id_memwrite;
    logic        stall;
    logic        flush;
    logic        exm_regwrite;
    logic [4:0]  exm_rd;
    logic [31:0] exm_result;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic        ex_valid;
    logic [3:0]  ex_aluctr;
    logic [31:0] alu1;
    logic [31:0] alu2;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;
    logic        ex_memread;
    logic        ex_memwrite;

    out_t obs;
    out_t exp;
    out_t exp_q[$];
    int   vectors;
    int   miscompares;

    id_ex_stage #(.DATA_WIDTH(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_aluctr(id_aluctr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_shamt(id_shamt),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alu1_sel(id_alu1_sel), .id_alu2_sel(id_alu2_sel),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .stall(stall), .flush(flush),
        .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
        .ex_valid(ex_valid), .ex_aluctr(ex_aluctr),
        .alu1(alu1), .alu2(alu2), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite)
    );

    assign obs = {ex_valid, ex_aluctr, alu1, alu2, ex_store_data, ex_rd,
                  ex_regwrite, ex_memread, ex_memwrite};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic out_t mk(logic v, logic [3:0] op, logic [31:0] a1, logic [31:0] a2,
                                logic [31:0] st, logic [4:0] rd, logic rw, logic mr, logic mw);
        return {v, op, a1, a2, st, rd, rw, mr, mw};
    endfunction

    task automatic idle_id();
        id_valid = 0; id_aluctr = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_shamt = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_alu1_sel = 0; id_alu2_sel = 0;
        id_regwrite = 0; id_memread = 0; id_memwrite = 0;
    endtask

    task automatic clear_fwd();
        exm_regwrite = 0; exm_rd = 0; exm_result = 0;
        wb_regwrite = 0; wb_rd = 0; wb_result = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; stall = 0; flush = 0;
        idle_id();
        clear_fwd();
        #12;
        // A forward aimed at $0 must not leak into the reset outputs.
        exm_regwrite = 1; exm_rd = 0; exm_result = 32'd55;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL reset: got %h expected %h", obs, exp); end
        clear_fwd();
        rst_n = 1;
    endtask

    task automatic test_load_add();
        id_valid = 1; id_aluctr = ALU_ADD; id_rs = 1; id_rs_data = 5; id_rt = 2; id_rt_data = 7;
        id_rd = 3; id_regwrite = 1;
        exp_q.push_back(mk(1, ALU_ADD, 5, 7, 7, 3, 1, 0, 0));
        @(posedge clk); #1;
        idle_id();
        exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL load_add: got %h expected %h", obs, exp); end
    endtask

    task automatic test_fwd_priority();
        exm_regwrite = 1; exm_rd = 1; exm_result = 100;
        wb_regwrite = 1; wb_rd = 1; wb_result = 200;
        exp_q.push_back(mk(1, ALU_ADD, 100, 7, 7, 3, 1, 0, 0));
        #1;
        exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL fwd_exm_wins: got %h expected %h", obs, exp); end
        exm_regwrite = 0;
        exp_q.push_back(mk(1, ALU_ADD, 200, 7, 7, 3, 1, 0, 0));
        #1;
        exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL fwd_wb: got %h expected %h", obs, exp); end
        wb_regwrite = 0; exm_regwrite = 1; exm_rd = 2; exm_result = 300;
        exp_q.push_back(mk(1, ALU_ADD, 5, 300, 300, 3, 1, 0, 0));
        #1;
        exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL fwd_rt: got %h expected %h", obs, exp); end
        clear_fwd();
        exp_q.push_back(mk(1, ALU_ADD, 5, 7, 7, 3, 1, 0, 0));
        #1;
        exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL fwd_none: got %h expected %h", obs, exp); end
    endtask

    task automatic test_zero_reg();
        id_valid = 1; id_aluctr = ALU_OR; id_rs = 0; id_rs_data = 0; id_rt = 6; id_rt_data = 11;
        id_imm = 32'h1234; id_alu2_sel = 2'd1; id_rd = 7; id_regwrite = 1;
        exp_q.push_back(mk(1, ALU_OR, 0, 32'h1234, 11, 7, 1, 0, 0));
        @(posedge clk); #1;
        idle_id();
        exm_regwrite = 1; exm_rd = 0; exm_result = 55;
        wb_regwrite = 1; wb_rd = 0; wb_result = 66;
        #1;
        exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL zero_reg: got %h expected %h", obs, exp); end
        clear_fwd();
    endtask

    task automatic test_stall();
        id_valid = 1; id_aluctr = ALU_SUB; id_rs = 3; id_rs_data = 32'h10; id_rt = 4;
        id_rt_data = 32'h20; id_rd = 5; id_regwrite = 1;
        exp_q.push_back(mk(1, ALU_SUB, 32'h10, 32'h20, 32'h20, 5, 1, 0, 0));
        @(posedge clk); #1;
        exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL stall_setup: got %h expected %h", obs, exp); end
        // ID carries different content throughout the stall; it must not be captured.
        stall = 1;
        id_valid = 0; id_aluctr = ALU_AND; id_rt_data = 32'hdead; id_rd = 9; id_regwrite = 0;
        wb_regwrite = 1; wb_rd = 4; wb_result = 9;
        exp_q.push_back(mk(1, ALU_SUB, 32'h10, 9, 9, 5, 1, 0, 0));
        #1;
        exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL stall_cycle1: got %h expected %h", obs, exp); end
        @(posedge clk); #1;
        wb_regwrite = 0; wb_rd = 0; wb_result = 0;
        exp_q.push_back(mk(1, ALU_SUB, 32'h10, 9, 9, 5, 1, 0, 0));
        #1;
        exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL stall_cycle2: got %h expected %h", obs, exp); end
        @(posedge clk); #1;
        stall = 0;
        idle_id();
        exp_q.push_back(mk(1, ALU_SUB, 32'h10, 9, 9, 5, 1, 0, 0));
        #1;
        exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL stall_held: got %h expected %h", obs, exp); end
    endtask

    task automatic test_back_to_back();
        // Immediate shift: alu2 = zero-extended shamt.
        id_valid = 1; id_aluctr = ALU_SLL; id_rs = 8; id_rs_data = 3; id_shamt = 5;
        id_alu2_sel = 2'd2; id_rd = 8; id_regwrite = 1;
        exp_q.push_back(mk(1, ALU_SLL, 3, 5, 0, 8, 1, 0, 0));
        @(posedge clk); #1;
        exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL shamt_sel: got %h expected %h", obs, exp); end
        // Variable shift form: alu1 = rt, alu2 = rs; also a load.
        idle_id();
        id_valid = 1; id_aluctr = ALU_SRL; id_rs = 8; id_rs_data = 3; id_rt = 9; id_rt_data = 32'h80;
        id_alu1_sel = 1; id_alu2_sel = 2'd3; id_rd = 9; id_regwrite = 1; id_memread = 1;
        exp_q.push_back(mk(1, ALU_SRL, 32'h80, 3, 32'h80, 9, 1, 1, 0));
        @(posedge clk); #1;
        exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL var_shift: got %h expected %h", obs, exp); end
        // Store whose rs is being written back on the capture edge.
        idle_id();
        id_valid = 1; id_aluctr = ALU_ADD; id_rs = 10; id_rs_data = 1; id_rt = 11; id_rt_data = 32'habc;
        id_imm = 4; id_alu2_sel = 2'd1; id_memwrite = 1;
        wb_regwrite = 1; wb_rd = 10; wb_result = 32'h77;
        exp_q.push_back(mk(1, ALU_ADD, 32'h77, 4, 32'habc, 0, 0, 0, 1));
        @(posedge clk); #1;
        clear_fwd();
        idle_id();
        exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL write_through: got %h expected %h", obs, exp); end
    endtask

    task automatic test_flush_stall();
        id_valid = 1; id_aluctr = ALU_ADD; id_rs = 1; id_rs_data = 5; id_rt = 2; id_rt_data = 7;
        id_rd = 3; id_regwrite = 1; id_memwrite = 1;
        flush = 1; stall = 1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        flush = 0; stall = 0;
        idle_id();
        exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL flush_stall: got %h expected %h", obs, exp); end
    endtask

    task automatic test_reset_mid();
        id_valid = 1; id_aluctr = ALU_ADD; id_rs = 12; id_rs_data = 5; id_rt = 13; id_rt_data = 6;
        id_imm = 8; id_alu2_sel = 2'd1; id_memwrite = 1;
        exp_q.push_back(mk(1, ALU_ADD, 5, 8, 6, 0, 0, 0, 1));
        @(posedge clk); #1;
        exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL store_setup: got %h expected %h", obs, exp); end
        #1;
        stall = 1;
        rst_n = 0;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL async_reset: got %h expected %h", obs, exp); end
        idle_id();
        stall = 0;
        id_valid = 1; id_aluctr = ALU_AND; id_rs = 1; id_rs_data = 32'h0f; id_rt = 2;
        id_rt_data = 32'hf0; id_rd = 4; id_regwrite = 1;
        #2;
        rst_n = 1;
        exp_q.push_back(mk(1, ALU_AND, 32'h0f, 32'hf0, 32'hf0, 4, 1, 0, 0));
        @(posedge clk); #1;
        idle_id();
        exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL load_after_reset: got %h expected %h", obs, exp); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_load_add();
        test_fwd_priority();
        test_zero_reg();
        test_stall();
        test_back_to_back();
        test_flush_stall();
        test_reset_mid();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
